// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instruction_fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_DEFAULT   = 4096;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID register. Handles stall,
// redirect with squash, sticky fault detection and a fetch counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned IMEM_WORDS   = IMEM_WORDS_DEFAULT,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] word_idx;
  logic        in_range;

  assign word_idx = {2'b00, pc_q[31:2]};
  assign in_range = (word_idx < IMEM_WORDS);

  // Next-state selection: redirect beats stall beats normal advance.
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    count_d    = count_q;
    if (redirect_valid) begin
      // Squash: if_id_pc keeps its old value, only the payload is killed.
      pc_d       = word_align(redirect_target);
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d    = pc_q + 32'd4;
      if_pc_d = pc_q;
      if (in_range) begin
        if_instr_d = imem_rdata;
        if_valid_d = 1'b1;
        count_d    = count_q + 32'd1;
      end else begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        fault_d    = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= word_align(RESET_VECTOR);
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_instr = if_instr_q;
  assign if_id_valid = if_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's byte address. Captures the combinationally returned instruction word into an IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with squash, misaligned-target and out-of-range fault detection, and a fetch counter.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word aligned.
IMEM_WORDS, 4096, depth of instruction memory in 32-bit words; legal byte addresses are 0 .. 4*IMEM_WORDS-1.
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) injected on squash or fault.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
stall  input  1  hazard stall from decode/execute; hold PC and IF/ID
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  32  byte address of redirect destination
imem_addr  output  32  byte address to instruction memory (equals pc)
imem_rdata  input  32  instruction word returned combinationally for imem_addr
if_id_pc  output  32  PC of instruction held in IF/ID
if_id_instr  output  32  instruction held in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction
fetch_fault  output  1  sticky: misaligned redirect or out-of-range fetch seen
fetch_count  output  32  number of valid instructions loaded into IF/ID, wraps

Behaviour:
- Reset (async assert, sync-safe deassert assumed upstream): pc=RESET_VECTOR, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, fetch_fault=0, fetch_count=0. Reset mid-operation discards any pending redirect/stall immediately.
- imem_addr = pc, purely combinational; no extra latency. Instruction for pc is captured at the same edge that advances pc, so fetch-to-IF/ID latency is 1 cycle.
- Per-edge priority: redirect_valid > stall > normal advance.
- Redirect (regardless of stall): pc <= {redirect_target[31:2],2'b00}; IF/ID squashed (if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc unchanged); fetch_count unchanged. If redirect_target[1:0]!=0, fetch_fault<=1.
- Stall without redirect: pc, IF/ID, fetch_count all hold.
- Normal: pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC -> 0). Range check: in_range = (pc >> 2) < IMEM_WORDS.
  - In range: if_id_pc<=pc, if_id_instr<=imem_rdata, if_id_valid<=1, fetch_count<=fetch_count+1 (wraps).
  - Out of range: if_id_pc<=pc, if_id_instr<=NOP_INSTR, if_id_valid<=0, fetch_fault<=1, count unchanged; pc still advances.
- fetch_fault clears only on rst.
- Back-to-back redirects: each takes effect; a redirect in the cycle right after a redirect squashes again.
- pc[1:0] is always 0.

Decomposition:
- Shared defines in the project include header: NOP encoding, default reset vector, IMEM_WORDS constant (replacing literal 2**12 sizing).
- No sub-module needed; optional pc_next mux may be a function inside the module.

Test Plan:
- Reset then 4 free-run cycles, memory word k = 32'h1000_0000+k -> imem_addr 0,4,8,12,16; IF/ID shows pc 0..12 with matching words, valid=1, fetch_count=4.
- Stall high for 3 cycles at pc=8 -> imem_addr stays 8, IF/ID and fetch_count frozen; release -> resumes at 8 with no skipped or duplicated instruction.
- Redirect to 32'h0000_0100 with stall also high -> next pc=0x100, if_id_valid=0, if_id_instr=32'h0000_0013, count unchanged; next cycle IF/ID pc=0x100, valid=1.
- Redirect to 32'h0000_0102 -> pc=0x100, fetch_fault=1 and stays 1 through 10 further cycles until rst.
- Redirect to 32'h0000_3FFC (last word) -> IF/ID valid with that word; next cycle pc=0x4000 captured as invalid NOP, fetch_fault=1.
- Assert rst asynchronously mid-cycle while redirect_valid=1 -> outputs go to reset values before next clk edge; after deassert, fetch starts at RESET_VECTOR.
